// File: rtl/mul_ctrl.sv
// Multiply-request controller: conditions operands to magnitude/sign form, sequences an
// external iterative multiplier and short-circuits repeated requests through a 1-entry cache.
module mul_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_rs1_i,
  input  logic [31:0] req_rs2_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        res_valid_o,
  output logic [31:0] res_o,
  output logic        mul_start_o,
  output logic        mul_cancel_o,
  output logic        mul_signed_o,
  output logic [31:0] mul_op1_o,
  output logic [31:0] mul_op2_o,
  input  logic        mul_stop_i,
  input  logic [31:0] mul_res_l_i,
  input  logic [31:0] mul_res_h_i
);
  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_op1, r_op2, r_rs1, r_rs2;
  logic        r_neg, r_s1, r_s2;
  logic [1:0]  r_op;
  logic [63:0] r_res;

  logic        r_c_vld, r_c_s1, r_c_s2;
  logic [31:0] r_c_rs1, r_c_rs2;
  logic [63:0] r_c_res;

  logic        w_s1, w_s2, w_neg1, w_neg2, w_hit, w_accept, w_capture;
  logic [31:0] w_mag1, w_mag2;

  function automatic logic [31:0] sel_res(input logic [1:0] op, input logic [63:0] p);
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  assign w_s1   = (req_op_i == OP_MULH) || (req_op_i == OP_MULHSU);
  assign w_s2   = (req_op_i == OP_MULH);
  assign w_neg1 = w_s1 & req_rs1_i[31];
  assign w_neg2 = w_s2 & req_rs2_i[31];
  // 0x80000000 negates to itself, which is exactly its magnitude as unsigned
  assign w_mag1 = w_neg1 ? (~req_rs1_i + 32'd1) : req_rs1_i;
  assign w_mag2 = w_neg2 ? (~req_rs2_i + 32'd1) : req_rs2_i;

  // MUL low word does not depend on signedness, so any cached pair serves it
  assign w_hit = (r_state == IDLE) & req_valid_i & r_c_vld &
                 (req_rs1_i == r_c_rs1) & (req_rs2_i == r_c_rs2) &
                 ((req_op_i == OP_MUL) | ({w_s1, w_s2} == {r_c_s1, r_c_s2}));

  assign mul_op1_o    = r_op1;
  assign mul_op2_o    = r_op2;
  assign mul_signed_o = r_neg;

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    stall_o      = 1'b0;
    res_valid_o  = 1'b0;
    res_o        = 32'h0;
    mul_start_o  = 1'b0;
    mul_cancel_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (!flush_i && w_hit) begin
          res_valid_o = 1'b1;
          res_o       = sel_res(req_op_i, r_c_res);
        end else if (!flush_i && req_valid_i) begin
          w_accept    = 1'b1;
          stall_o     = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        stall_o     = 1'b1;
        mul_start_o = 1'b1;
        if (flush_i) begin
          mul_cancel_o = 1'b1;
          w_state_nxt  = IDLE;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        // a flush coinciding with the stop wins: the product is dropped
        if (flush_i) begin
          mul_cancel_o = 1'b1;
          w_state_nxt  = IDLE;
        end else if (mul_stop_i) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        if (!flush_i) begin
          res_valid_o = 1'b1;
          res_o       = sel_res(r_op, r_res);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op1   <= 32'h0;
      r_op2   <= 32'h0;
      r_rs1   <= 32'h0;
      r_rs2   <= 32'h0;
      r_neg   <= 1'b0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_op    <= 2'b00;
      r_res   <= 64'h0;
      r_c_vld <= 1'b0;
      r_c_s1  <= 1'b0;
      r_c_s2  <= 1'b0;
      r_c_rs1 <= 32'h0;
      r_c_rs2 <= 32'h0;
      r_c_res <= 64'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op1 <= w_mag1;
        r_op2 <= w_mag2;
        r_neg <= w_neg1 ^ w_neg2;
        r_op  <= req_op_i;
        r_rs1 <= req_rs1_i;
        r_rs2 <= req_rs2_i;
        r_s1  <= w_s1;
        r_s2  <= w_s2;
      end
      if (w_capture) begin
        r_res   <= {mul_res_h_i, mul_res_l_i};
        r_c_vld <= 1'b1;
        r_c_rs1 <= r_rs1;
        r_c_rs2 <= r_rs2;
        r_c_s1  <= r_s1;
        r_c_s2  <= r_s2;
        r_c_res <= {mul_res_h_i, mul_res_l_i};
      end
    end
  end
endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: plays the multiplier itself and predicts results and cache hits
// from plain 64-bit arithmetic.
module tb_mul_ctrl;
  logic        clk = 1'b0;
  logic        rst, req_valid_i, flush_i, mul_stop_i;
  logic [1:0]  req_op_i;
  logic [31:0] req_rs1_i, req_rs2_i, mul_res_l_i, mul_res_h_i;
  logic        stall_o, res_valid_o, mul_start_o, mul_cancel_o, mul_signed_o;
  logic [31:0] res_o, mul_op1_o, mul_op2_o;

  int n_cmp = 0, n_fail = 0;

  // reference view of the one-entry result cache
  bit          m_vld = 1'b0;
  logic [31:0] m_rs1, m_rs2;
  bit          m_s1, m_s2;

  always #5 clk = ~clk;

  mul_ctrl dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_op_i(req_op_i),
    .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .flush_i(flush_i),
    .stall_o(stall_o), .res_valid_o(res_valid_o), .res_o(res_o),
    .mul_start_o(mul_start_o), .mul_cancel_o(mul_cancel_o), .mul_signed_o(mul_signed_o),
    .mul_op1_o(mul_op1_o), .mul_op2_o(mul_op2_o), .mul_stop_i(mul_stop_i),
    .mul_res_l_i(mul_res_l_i), .mul_res_h_i(mul_res_h_i)
  );

  function automatic logic [63:0] ref_prod(input logic [1:0] op, input logic [31:0] a, b);
    logic [63:0] ea, eb;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] ref_mag(input logic [31:0] v, input bit neg);
    return neg ? 32'h0 - v : v;
  endfunction

  // One request, either served from the cache or run through the multiplier
  // (lat idle BUSY cycles before the stop). fl_done flushes in the DONE cycle.
  task automatic do_req(input logic [1:0] op, input logic [31:0] a, b, input int lat,
                        input bit fl_done, input string tag);
    logic [63:0] p;
    logic [31:0] er, m1, m2;
    bit s1, s2, sg, hit;
    s1  = (op == 2'b01 || op == 2'b10);
    s2  = (op == 2'b01);
    m1  = ref_mag(a, s1 & a[31]);
    m2  = ref_mag(b, s2 & b[31]);
    sg  = (s1 & a[31]) ^ (s2 & b[31]);
    p   = ref_prod(op, a, b);
    er  = (op == 2'b00) ? p[31:0] : p[63:32];
    hit = m_vld && a == m_rs1 && b == m_rs2 && (op == 2'b00 || (s1 == m_s1 && s2 == m_s2));
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = op; req_rs1_i = a; req_rs2_i = b; #1;
    if (hit) begin
      n_cmp++;
      if ({res_valid_o, stall_o, mul_start_o, res_o} !== {3'b100, er}) begin
        n_fail++;
        $display("FAIL %s_hit: got vld=%b stall=%b start=%b res=%h, want 1 0 0 %h",
                 tag, res_valid_o, stall_o, mul_start_o, res_o, er);
      end
      @(negedge clk); req_valid_i = 1'b0; #1;
      n_cmp++;
      if ({res_valid_o, stall_o, mul_start_o} !== 3'b000) begin
        n_fail++;
        $display("FAIL %s_after_hit: got vld/stall/start=%b%b%b, want 000",
                 tag, res_valid_o, stall_o, mul_start_o);
      end
    end else begin
      n_cmp++;
      if ({stall_o, res_valid_o, mul_start_o} !== 3'b100) begin
        n_fail++;
        $display("FAIL %s_accept: got stall/vld/start=%b%b%b, want 100",
                 tag, stall_o, res_valid_o, mul_start_o);
      end
      @(negedge clk); #1;
      n_cmp++;
      if ({stall_o, mul_start_o, res_valid_o, mul_signed_o, mul_op1_o, mul_op2_o} !==
          {3'b110, sg, m1, m2}) begin
        n_fail++;
        $display("FAIL %s_start: got stall=%b start=%b vld=%b sgn=%b op1=%h op2=%h, want 1 1 0 %b %h %h",
                 tag, stall_o, mul_start_o, res_valid_o, mul_signed_o, mul_op1_o, mul_op2_o, sg, m1, m2);
      end
      for (int i = 0; i <= lat; i++) begin
        @(negedge clk);
        mul_res_h_i = $urandom; mul_res_l_i = $urandom;
        if (i == lat) begin
          mul_stop_i = 1'b1; {mul_res_h_i, mul_res_l_i} = p;
        end
        #1;
        n_cmp++;
        if ({stall_o, mul_start_o, res_valid_o, mul_signed_o, mul_op1_o, mul_op2_o} !==
            {3'b100, sg, m1, m2}) begin
          n_fail++;
          $display("FAIL %s_busy%0d: got stall=%b start=%b vld=%b sgn=%b op1=%h op2=%h",
                   tag, i, stall_o, mul_start_o, res_valid_o, mul_signed_o, mul_op1_o, mul_op2_o);
        end
      end
      @(negedge clk);
      mul_stop_i = 1'b0; mul_res_h_i = $urandom; mul_res_l_i = $urandom; flush_i = fl_done; #1;
      n_cmp++;
      if (fl_done) begin
        if ({res_valid_o, stall_o} !== 2'b00) begin
          n_fail++;
          $display("FAIL %s_done_flush: got vld=%b stall=%b, want 0 0", tag, res_valid_o, stall_o);
        end
      end else if ({res_valid_o, stall_o, mul_start_o, res_o, mul_signed_o, mul_op1_o, mul_op2_o} !==
                   {3'b100, er, sg, m1, m2}) begin
        n_fail++;
        $display("FAIL %s_done: got vld=%b stall=%b start=%b res=%h sgn=%b op1=%h op2=%h, want res=%h",
                 tag, res_valid_o, stall_o, mul_start_o, res_o, mul_signed_o, mul_op1_o, mul_op2_o, er);
      end
      m_vld = 1'b1; m_rs1 = a; m_rs2 = b; m_s1 = s1; m_s2 = s2;
      @(negedge clk); req_valid_i = 1'b0; flush_i = 1'b0; #1;
      n_cmp++;
      if ({res_valid_o, stall_o, mul_start_o} !== 3'b000) begin
        n_fail++;
        $display("FAIL %s_idle: got vld/stall/start=%b%b%b, want 000",
                 tag, res_valid_o, stall_o, mul_start_o);
      end
    end
  endtask

  // Miss that gets abandoned: mode 0 flush in BUSY, 1 flush with stop, 2 reset in BUSY,
  // 3 flush in START. The caller supplies operands that miss the cache.
  task automatic abort_req(input logic [1:0] op, input logic [31:0] a, b, input int nbusy,
                           input int mode, input string tag);
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = op; req_rs1_i = a; req_rs2_i = b; #1;
    n_cmp++;
    if (stall_o !== 1'b1) begin
      n_fail++; $display("FAIL %s_accept: got stall=%b, want 1", tag, stall_o);
    end
    @(negedge clk);
    if (mode == 3) flush_i = 1'b1;
    #1;
    n_cmp++;
    if ({mul_start_o, mul_cancel_o} !== {1'b1, mode == 3}) begin
      n_fail++;
      $display("FAIL %s_start: got start=%b cancel=%b, want 1 %b", tag, mul_start_o, mul_cancel_o, mode == 3);
    end
    if (mode != 3) begin
      for (int i = 0; i < nbusy; i++) begin
        @(negedge clk); #1;
        n_cmp++;
        if ({stall_o, mul_cancel_o, res_valid_o} !== 3'b100) begin
          n_fail++;
          $display("FAIL %s_busy%0d: got stall/cancel/vld=%b%b%b, want 100",
                   tag, i, stall_o, mul_cancel_o, res_valid_o);
        end
      end
      @(negedge clk);
      if (mode == 2) rst = 1'b1;
      else flush_i = 1'b1;
      if (mode == 1) begin
        mul_stop_i = 1'b1; {mul_res_h_i, mul_res_l_i} = ref_prod(op, a, b);
      end
      #1;
      n_cmp++;
      if ({mul_cancel_o, res_valid_o} !== {mode != 2, 1'b0}) begin
        n_fail++;
        $display("FAIL %s_event: got cancel=%b vld=%b, want %b 0", tag, mul_cancel_o, res_valid_o, mode != 2);
      end
    end
    @(negedge clk);
    flush_i = 1'b0; mul_stop_i = 1'b0; rst = 1'b0; req_valid_i = 1'b0; #1;
    n_cmp++;
    if ({stall_o, res_valid_o, mul_start_o, mul_cancel_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s_after: got stall/vld/start/cancel=%b%b%b%b, want 0000",
               tag, stall_o, res_valid_o, mul_start_o, mul_cancel_o);
    end
    if (mode == 2) begin
      m_vld = 1'b0;
      n_cmp++;
      if ({mul_signed_o, mul_op1_o, mul_op2_o, res_o} !== 97'h0) begin
        n_fail++;
        $display("FAIL %s_rst_regs: got sgn=%b op1=%h op2=%h res=%h, want all 0",
                 tag, mul_signed_o, mul_op1_o, mul_op2_o, res_o);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid_i = 1'b0; flush_i = 1'b0; mul_stop_i = 1'b0;
    req_op_i = 2'b00; req_rs1_i = 32'h0; req_rs2_i = 32'h0;
    mul_res_l_i = 32'h0; mul_res_h_i = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    n_cmp++;
    if ({stall_o, res_valid_o, mul_start_o, mul_cancel_o, mul_signed_o, mul_op1_o, mul_op2_o, res_o}
        !== 101'h0) begin
      n_fail++;
      $display("FAIL reset: got stall=%b vld=%b start=%b cancel=%b sgn=%b op1=%h op2=%h res=%h, want all 0",
               stall_o, res_valid_o, mul_start_o, mul_cancel_o, mul_signed_o, mul_op1_o, mul_op2_o, res_o);
    end
  endtask

  task automatic test_vectors;
    do_req(2'b00, 32'd7, 32'hFFFFFFFD, 2, 1'b0, "mul_neg");
    do_req(2'b01, 32'h80000000, 32'h80000000, 1, 1'b0, "mulh_min");
    do_req(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 1'b0, "mulhsu_ones");
    do_req(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, "mulhu_ones");
  endtask

  task automatic test_cache_hit;
    do_req(2'b01, 32'h12345678, 32'h9ABCDEF0, 4, 1'b0, "hit_fill");
    do_req(2'b00, 32'h12345678, 32'h9ABCDEF0, 0, 1'b0, "hit_mul");
    do_req(2'b01, 32'h12345678, 32'h9ABCDEF0, 0, 1'b0, "hit_mulh");
    do_req(2'b11, 32'h12345678, 32'h9ABCDEF0, 1, 1'b0, "miss_mulhu");
  endtask

  task automatic test_flush;
    abort_req(2'b01, 32'h11112222, 32'h33334444, 5, 0, "flush_busy");
    do_req(2'b01, 32'h11112222, 32'h33334444, 2, 1'b0, "flush_busy_retry");
    abort_req(2'b10, 32'hDEADBEEF, 32'h5, 2, 1, "flush_stop");
    do_req(2'b10, 32'hDEADBEEF, 32'h5, 1, 1'b0, "flush_stop_retry");
    abort_req(2'b00, 32'h55, 32'h66, 0, 3, "flush_start");
    do_req(2'b11, 32'hCAFE0000, 32'h0000BABE, 1, 1'b1, "flush_done");
    do_req(2'b11, 32'hCAFE0000, 32'h0000BABE, 0, 1'b0, "after_flush_done");
  endtask

  task automatic test_flush_idle;
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = 2'b00; req_rs1_i = m_rs1; req_rs2_i = m_rs2; flush_i = 1'b1; #1;
    n_cmp++;
    if ({res_valid_o, stall_o} !== 2'b00) begin
      n_fail++; $display("FAIL flush_idle: got vld=%b stall=%b, want 0 0", res_valid_o, stall_o);
    end
    @(negedge clk); req_valid_i = 1'b0; flush_i = 1'b0; #1;
    n_cmp++;
    if ({mul_start_o, stall_o} !== 2'b00) begin
      n_fail++; $display("FAIL flush_idle_next: got start=%b stall=%b, want 0 0", mul_start_o, stall_o);
    end
  endtask

  task automatic test_stray_stop;
    @(negedge clk);
    mul_stop_i = 1'b1; #1;
    @(negedge clk); mul_stop_i = 1'b0; #1;
    n_cmp++;
    if ({res_valid_o, stall_o, mul_start_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL stray_stop: got vld/stall/start=%b%b%b, want 000", res_valid_o, stall_o, mul_start_o);
    end
  endtask

  task automatic test_rst_mid;
    do_req(2'b00, 32'h1000, 32'h2000, 1, 1'b0, "rst_fill");
    abort_req(2'b00, 32'h3000, 32'h4000, 3, 2, "rst_busy");
    do_req(2'b00, 32'h1000, 32'h2000, 1, 1'b0, "rst_refill");
  endtask

  task automatic test_zero;
    do_req(2'b01, 32'h0, 32'h12345, 0, 1'b0, "zero_a");
    do_req(2'b00, 32'h0, 32'h0, 0, 1'b0, "zero_both");
  endtask

  task automatic test_random;
    logic [31:0] pool [5];
    logic [31:0] a, b;
    pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'h80000000; pool[3] = 32'hFFFFFFFF; pool[4] = 32'h7FFFFFFF;
    for (int n = 0; n < 40; n++) begin
      if (m_vld && $urandom_range(0, 9) < 4) begin
        a = m_rs1; b = m_rs2;
      end else begin
        a = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
        b = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      end
      do_req(2'($urandom_range(0, 3)), a, b, $urandom_range(0, 5), 1'b0, "rand");
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_cache_hit;
    test_flush;
    test_flush_idle;
    test_stray_stop;
    test_rst_mid;
    test_zero;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
